// File: rtl/pifo_task_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pifo_task_arbiter
// Purpose  : Multi-channel task front end for the SRAM-based PIFO core.
//            Each client channel queues push/pop tasks in its own task FIFO.
//            A round-robin arbiter moves channel heads into a single-stage
//            command register that drives a valid/ready command port. Channel
//            ids of issued pops are kept in an in-order tag FIFO so that pop
//            responses can be steered back to the channel that asked.
// Ports    : i_clk, i_arst_n        clock, asynchronous active-low reset
//            i_push/i_pop [CH]      per-channel task requests
//            i_push_data [CH*DW]    per-channel push data (slice c*DW)
//            i_tree_id [CH*TREE_W]  per-channel tree id (slice c*TREE_W)
//            o_task_fifo_full [CH]  channel FIFO holds DEPTH entries
//            o_overflow [CH]        one-cycle pulse, request dropped
//            o_cmd_* / i_cmd_ready  command port toward the PIFO core
//            i_rsp_valid/i_rsp_data in-order pop responses from the core
//            o_pop_valid/o_pop_data per-channel pop result delivery
//            o_rsp_err              sticky, response with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module pifo_task_arbiter #(
  parameter  int CH     = 4,
  parameter  int PTW    = 8,
  parameter  int MTW    = 0,
  parameter  int TREE_W = 2,
  parameter  int DEPTH  = 4,
  parameter  int OUTS   = 4,
  localparam int DW     = PTW + MTW,
  localparam int CHW    = $clog2(CH)
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic [CH-1:0]        i_push,
  input  logic [CH-1:0]        i_pop,
  input  logic [CH*DW-1:0]     i_push_data,
  input  logic [CH*TREE_W-1:0] i_tree_id,
  output logic [CH-1:0]        o_task_fifo_full,
  output logic [CH-1:0]        o_overflow,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic                 o_cmd_push,
  output logic                 o_cmd_pop,
  output logic [TREE_W-1:0]    o_cmd_tree_id,
  output logic [DW-1:0]        o_cmd_data,
  output logic [CHW-1:0]       o_cmd_ch,
  input  logic                 i_rsp_valid,
  input  logic [DW-1:0]        i_rsp_data,
  output logic [CH-1:0]        o_pop_valid,
  output logic [CH*DW-1:0]     o_pop_data,
  output logic                 o_rsp_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(OUTS);
  localparam int TCW  = TW + 1;
  localparam int CHW1 = CHW + 1;
  // Task entry layout: {push, pop, tree_id, data}
  localparam int EW     = 2 + TREE_W + DW;
  localparam int PUSH_B = EW - 1;
  localparam int POP_B  = EW - 2;

  logic [CH-1:0][EW-1:0] head_w;
  logic [CH-1:0]         nonempty_w;
  logic [CH-1:0]         elig_w;
  logic [CH-1:0]         deq_w;

  logic                  gnt_found_w;
  logic [CHW-1:0]        gnt_idx_w;
  logic [EW-1:0]         gnt_head_w;
  logic                  cmd_load_w;
  logic [CHW-1:0]        rr_q, rr_d;

  logic                  cmd_valid_q, cmd_push_q, cmd_pop_q;
  logic [TREE_W-1:0]     cmd_tree_q;
  logic [DW-1:0]         cmd_data_q;
  logic [CHW-1:0]        cmd_ch_q;

  logic [CHW-1:0]        tmem_q [OUTS];
  logic [TW-1:0]         twr_q, trd_q;
  logic [TCW-1:0]        tcnt_q, tcnt_d;
  logic                  tag_push_w, tag_pop_w;
  logic [CHW-1:0]        tag_head_w;

  logic [CH-1:0]         pop_valid_q;
  logic [CH-1:0][DW-1:0] pop_data_q;
  logic                  rsp_err_q;

  // --------------------------------------------------------------------------
  // Per-channel task FIFOs
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, ovf_q;
    logic          req_w, at_depth_w, wr_w;
    logic [DW-1:0] wdata_w;

    assign req_w      = i_push[c] | i_pop[c];
    // Full is judged on the pre-edge count: a same-cycle dequeue never
    // makes room for a request that arrives while the FIFO is at DEPTH.
    assign at_depth_w = (cnt_q == CW'(DEPTH));
    assign wr_w       = req_w & ~at_depth_w;
    assign wdata_w    = i_push[c] ? i_push_data[c*DW +: DW] : '0;
    assign cnt_d      = cnt_q + CW'(wr_w) - CW'(deq_w[c]);

    assign head_w[c]           = mem_q[rptr_q];
    assign nonempty_w[c]       = (cnt_q != '0);
    assign o_task_fifo_full[c] = full_q;
    assign o_overflow[c]       = ovf_q;

    always_ff @(posedge i_clk) begin
      if (wr_w) begin
        mem_q[wptr_q] <= {i_push[c], i_pop[c], i_tree_id[c*TREE_W +: TREE_W], wdata_w};
      end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        full_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (wr_w) begin
          wptr_q <= wptr_q + 1'b1;
        end
        if (deq_w[c]) begin
          rptr_q <= rptr_q + 1'b1;
        end
        cnt_q  <= cnt_d;
        full_q <= (cnt_d == CW'(DEPTH));
        ovf_q  <= req_w & at_depth_w;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Eligibility and round-robin grant
  // --------------------------------------------------------------------------
  // A head carrying a pop needs a free tag slot; the slot is reserved when the
  // head is loaded into the command register.
  always_comb begin
    elig_w = '0;
    for (int c = 0; c < CH; c++) begin
      elig_w[c] = nonempty_w[c] & (~head_w[c][POP_B] | (tcnt_q != TCW'(OUTS)));
    end
  end

  always_comb begin
    logic [CHW1-1:0] cand;
    cand        = '0;
    gnt_found_w = 1'b0;
    gnt_idx_w   = '0;
    for (int i = 0; i < CH; i++) begin
      cand = {1'b0, rr_q} + CHW1'(i);
      if (cand >= CHW1'(CH)) begin
        cand = cand - CHW1'(CH);
      end
      if (!gnt_found_w && elig_w[cand[CHW-1:0]]) begin
        gnt_found_w = 1'b1;
        gnt_idx_w   = cand[CHW-1:0];
      end
    end
  end

  assign gnt_head_w = head_w[gnt_idx_w];
  assign cmd_load_w = gnt_found_w & (~cmd_valid_q | i_cmd_ready);

  always_comb begin
    deq_w = '0;
    rr_d  = rr_q;
    if (cmd_load_w) begin
      deq_w[gnt_idx_w] = 1'b1;
      rr_d = (gnt_idx_w == CHW'(CH - 1)) ? '0 : gnt_idx_w + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Command register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_push_q  <= 1'b0;
      cmd_pop_q   <= 1'b0;
      cmd_tree_q  <= '0;
      cmd_data_q  <= '0;
      cmd_ch_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (cmd_load_w) begin
        cmd_valid_q <= 1'b1;
        cmd_push_q  <= gnt_head_w[PUSH_B];
        cmd_pop_q   <= gnt_head_w[POP_B];
        cmd_tree_q  <= gnt_head_w[DW +: TREE_W];
        cmd_data_q  <= gnt_head_w[DW-1:0];
        cmd_ch_q    <= gnt_idx_w;
      end else if (i_cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign o_cmd_valid   = cmd_valid_q;
  assign o_cmd_push    = cmd_push_q;
  assign o_cmd_pop     = cmd_pop_q;
  assign o_cmd_tree_id = cmd_tree_q;
  assign o_cmd_data    = cmd_data_q;
  assign o_cmd_ch      = cmd_ch_q;

  // --------------------------------------------------------------------------
  // Outstanding-pop tag FIFO and response steering
  // --------------------------------------------------------------------------
  assign tag_push_w = cmd_load_w & gnt_head_w[POP_B];
  // A response is matched against tags present before this edge; a tag being
  // written in the same cycle belongs to a pop the core has not yet seen.
  assign tag_pop_w  = i_rsp_valid & (tcnt_q != '0);
  assign tag_head_w = tmem_q[trd_q];
  assign tcnt_d     = tcnt_q + TCW'(tag_push_w) - TCW'(tag_pop_w);

  always_ff @(posedge i_clk) begin
    if (tag_push_w) begin
      tmem_q[twr_q] <= gnt_idx_w;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      twr_q       <= '0;
      trd_q       <= '0;
      tcnt_q      <= '0;
      pop_valid_q <= '0;
      pop_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (tag_push_w) begin
        twr_q <= twr_q + 1'b1;
      end
      if (tag_pop_w) begin
        trd_q <= trd_q + 1'b1;
      end
      tcnt_q      <= tcnt_d;
      pop_valid_q <= '0;
      if (tag_pop_w) begin
        pop_valid_q[tag_head_w] <= 1'b1;
        pop_data_q[tag_head_w]  <= i_rsp_data;
      end
      if (i_rsp_valid && (tcnt_q == '0)) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign o_pop_valid = pop_valid_q;
  assign o_pop_data  = pop_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pifo_task_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pifo_task_arbiter
// Purpose  : Self-checking bench for pifo_task_arbiter. A queue-based
//            reference model tracks channel task queues, the command slot,
//            outstanding pops and the round-robin pointer; expected commands
//            and pop responses go to scoreboard queues that a monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_task_arbiter;

  localparam int CH     = 4;
  localparam int PTW    = 8;
  localparam int MTW    = 0;
  localparam int TREE_W = 2;
  localparam int DEPTH  = 4;
  localparam int OUTS   = 4;
  localparam int DW     = PTW + MTW;
  localparam int CHW    = $clog2(CH);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [CH-1:0]        tb_push = '0;
  logic [CH-1:0]        tb_pop = '0;
  logic [CH*DW-1:0]     tb_data = '0;
  logic [CH*TREE_W-1:0] tb_tree = '0;
  logic                 cmd_ready = 1'b0;
  logic                 rsp_valid = 1'b0;
  logic [DW-1:0]        rsp_data = '0;

  logic [CH-1:0]        o_task_fifo_full, o_overflow, o_pop_valid;
  logic                 o_cmd_valid, o_cmd_push, o_cmd_pop, o_rsp_err;
  logic [TREE_W-1:0]    o_cmd_tree_id;
  logic [DW-1:0]        o_cmd_data;
  logic [CHW-1:0]       o_cmd_ch;
  logic [CH*DW-1:0]     o_pop_data;
  logic [59:0]          all_out;

  assign all_out = {o_cmd_valid, o_cmd_push, o_cmd_pop, o_cmd_tree_id, o_cmd_data,
                    o_cmd_ch, o_pop_valid, o_pop_data, o_rsp_err, o_overflow,
                    o_task_fifo_full};

  always #5 clk = ~clk;

  pifo_task_arbiter #(
    .CH(CH), .PTW(PTW), .MTW(MTW), .TREE_W(TREE_W), .DEPTH(DEPTH), .OUTS(OUTS)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_push(tb_push), .i_pop(tb_pop), .i_push_data(tb_data), .i_tree_id(tb_tree),
    .o_task_fifo_full(o_task_fifo_full), .o_overflow(o_overflow),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_push(o_cmd_push), .o_cmd_pop(o_cmd_pop), .o_cmd_tree_id(o_cmd_tree_id),
    .o_cmd_data(o_cmd_data), .o_cmd_ch(o_cmd_ch),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
    .o_pop_valid(o_pop_valid), .o_pop_data(o_pop_data), .o_rsp_err(o_rsp_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_ch1_pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic              is_push;
    logic              is_pop;
    logic [TREE_W-1:0] tree;
    logic [DW-1:0]     data;
  } task_t;

  typedef struct packed {
    task_t          t;
    logic [CHW-1:0] ch;
  } cmd_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  d;
  } rsp_t;

  task_t   mq [CH][$];
  int      m_tags[$];
  cmd_t    exp_cmd[$];
  rsp_t    exp_rsp[$];
  bit      m_slot_v = 1'b0;
  int      m_rr = 0;
  logic [CH-1:0] m_full = '0;
  logic [CH-1:0] m_ovf = '0;
  logic    m_err = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) mq[i].delete();
    m_tags.delete();
    exp_cmd.delete();
    exp_rsp.delete();
    m_slot_v = 1'b0;
    m_rr     = 0;
    m_full   = '0;
    m_ovf    = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    int    sz [CH];
    int    ntag;
    bit    acc;
    int    g;
    int    c;
    task_t t;
    cmd_t  e;
    rsp_t  r;
    ntag = m_tags.size();
    acc  = m_slot_v && cmd_ready;
    for (int i = 0; i < CH; i++) sz[i] = mq[i].size();
    // response against the tags present before this edge
    if (rsp_valid) begin
      if (ntag > 0) begin
        r.ch = CHW'(m_tags.pop_front());
        r.d  = rsp_data;
        exp_rsp.push_back(r);
      end else begin
        m_err = 1'b1;
      end
    end
    // round-robin grant into the command slot
    if (!m_slot_v || acc) begin
      g = -1;
      for (int i = 0; i < CH; i++) begin
        c = (m_rr + i) % CH;
        if (g < 0 && sz[c] > 0) begin
          t = mq[c][0];
          if (!t.is_pop || ntag < OUTS) g = c;
        end
      end
      if (g >= 0) begin
        t    = mq[g].pop_front();
        e.t  = t;
        e.ch = CHW'(g);
        exp_cmd.push_back(e);
        m_slot_v = 1'b1;
        if (t.is_pop) m_tags.push_back(g);
        m_rr = (g + 1) % CH;
      end else begin
        m_slot_v = 1'b0;
      end
    end
    // enqueue against the pre-edge occupancy
    for (int i = 0; i < CH; i++) begin
      m_ovf[i] = 1'b0;
      if (tb_push[i] || tb_pop[i]) begin
        if (sz[i] >= DEPTH) begin
          m_ovf[i] = 1'b1;
        end else begin
          t.is_push = tb_push[i];
          t.is_pop  = tb_pop[i];
          t.tree    = tb_tree[i*TREE_W +: TREE_W];
          t.data    = tb_push[i] ? tb_data[i*DW +: DW] : '0;
          mq[i].push_back(t);
        end
      end
      m_full[i] = (mq[i].size() == DEPTH);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  bit          stall_prev = 1'b0;
  logic [13:0] prev_fields = '0;
  logic [13:0] cur_fields;
  assign cur_fields = {o_cmd_push, o_cmd_pop, o_cmd_tree_id, o_cmd_data, o_cmd_ch};

  always @(negedge clk) begin
    cmd_t e;
    rsp_t r;
    if (rst_n) begin
      check("fifo_full", 64'(o_task_fifo_full), 64'(m_full));
      check("overflow", 64'(o_overflow), 64'(m_ovf));
      check("rsp_err", 64'(o_rsp_err), 64'(m_err));
      check("cmd_valid", 64'(o_cmd_valid), 64'(m_slot_v));
      if (stall_prev && o_cmd_valid) check("cmd_stable", 64'(cur_fields), 64'(prev_fields));
      if (o_cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cmd_unexpected: got 0x%0h expected none at %0t", cur_fields, $time);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_fields", 64'(cur_fields), 64'(e));
          if (o_cmd_pop && o_cmd_ch == CHW'(1)) n_ch1_pops++;
        end
      end
      stall_prev  = o_cmd_valid && !cmd_ready;
      prev_fields = cur_fields;
      if (o_pop_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected none at %0t", o_pop_valid, $time);
        end else begin
          r = exp_rsp.pop_front();
          check("pop_valid", 64'(o_pop_valid), 64'(CH'(1) << r.ch));
          check("pop_data", 64'(o_pop_data[r.ch*DW +: DW]), 64'(r.d));
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    tb_push   = '0;
    tb_pop    = '0;
    rsp_valid = 1'b0;
  endtask

  task automatic set_task(input int c, input bit p, input bit q, input logic [DW-1:0] d,
                          input logic [TREE_W-1:0] t);
    tb_push[c]                  = p;
    tb_pop[c]                   = q;
    tb_data[c*DW +: DW]         = d;
    tb_tree[c*TREE_W +: TREE_W] = t;
  endtask

  function automatic bit busy();
    bit b;
    b = m_slot_v || (m_tags.size() > 0);
    for (int i = 0; i < CH; i++) if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // Empties every queue, answering each outstanding pop with random data.
  task automatic drain(input int maxc);
    int n;
    n = 0;
    clear_inputs();
    cmd_ready = 1'b1;
    while (busy() && n < maxc) begin
      rsp_valid = (m_tags.size() > 0);
      rsp_data  = DW'($urandom);
      step();
      n++;
    end
    rsp_valid = 1'b0;
    step();
    if (n >= maxc) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, maxc);
    end
  endtask

  task automatic randomize_slices();
    for (int c = 0; c < CH; c++) begin
      tb_data[c*DW +: DW]         = DW'($urandom);
      tb_tree[c*TREE_W +: TREE_W] = TREE_W'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(all_out), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // channel 2 pushes 1,2,3 on tree 2
    cmd_ready = 1'b1;
    clear_inputs();
    set_task(2, 1'b1, 1'b0, 8'd1, 2'd2);
    step();
    check("lat_edge1_valid", 64'(o_cmd_valid), 64'd0);
    set_task(2, 1'b1, 1'b0, 8'd2, 2'd2);
    step();
    check("lat_edge2_valid", 64'(o_cmd_valid), 64'd1);
    check("first_cmd_data", 64'(o_cmd_data), 64'd1);
    check("first_cmd_ch", 64'(o_cmd_ch), 64'd2);
    set_task(2, 1'b1, 1'b0, 8'd3, 2'd2);
    step();
    drain(40);

    // channels 0,1,3 push every cycle
    for (int k = 0; k < 9; k++) begin
      clear_inputs();
      randomize_slices();
      tb_push = 4'b1011;
      step();
    end
    drain(60);

    // stalled core, six pushes on channel 1
    cmd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      set_task(1, 1'b1, 1'b0, 8'(8'h10 + k), 2'd1);
      step();
    end
    clear_inputs();
    check("full_ch1", 64'(o_task_fifo_full[1]), 64'd1);
    check("ovf_ch1", 64'(o_overflow[1]), 64'd1);
    step();
    check("ovf_ch1_single", 64'(o_overflow[1]), 64'd0);
    drain(40);

    // channel 0 push and channel 2 pop in the same cycle
    clear_inputs();
    set_task(0, 1'b1, 1'b0, 8'h07, 2'd1);
    set_task(2, 1'b0, 1'b1, 8'h00, 2'd3);
    step();
    clear_inputs();
    repeat (3) step();
    rsp_valid = 1'b1;
    rsp_data  = 8'h07;
    step();
    rsp_valid = 1'b0;
    check("pop_valid_ch2", 64'(o_pop_valid), 64'h4);
    check("pop_data_ch2", 64'(o_pop_data[2*DW +: DW]), 64'h07);
    drain(40);

    // outstanding pop limit
    n_ch1_pops = 0;
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      set_task(1, 1'b0, 1'b1, 8'h00, 2'(k));
      step();
    end
    clear_inputs();
    repeat (8) step();
    check("outs_limit", 64'(n_ch1_pops), 64'd4);
    rsp_valid = 1'b1;
    rsp_data  = DW'($urandom);
    step();
    rsp_valid = 1'b0;
    repeat (4) step();
    check("outs_after_rsp", 64'(n_ch1_pops), 64'd5);
    drain(60);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      randomize_slices();
      tb_push   = CH'($urandom);
      tb_pop    = CH'($urandom & $urandom & $urandom);
      cmd_ready = (($urandom % 4) != 0);
      rsp_valid = (m_tags.size() > 0) && (($urandom % 3) == 0);
      rsp_data  = DW'($urandom);
      step();
    end
    drain(200);

    // response with nothing outstanding
    rsp_valid = 1'b1;
    rsp_data  = 8'h33;
    step();
    rsp_valid = 1'b0;
    step();
    check("rsp_err_set", 64'(o_rsp_err), 64'd1);
    repeat (5) step();
    check("rsp_err_sticky", 64'(o_rsp_err), 64'd1);

    // reset in the middle of a burst
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      randomize_slices();
      tb_push = CH'($urandom);
      step();
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      randomize_slices();
      tb_push = CH'($urandom);
      tb_pop  = CH'($urandom);
      step();
    end
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", 64'(all_out), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_task(3, 1'b1, 1'b0, 8'h5A, 2'd1);
    step();
    clear_inputs();
    step();
    check("post_reset_valid", 64'(o_cmd_valid), 64'd1);
    check("post_reset_data", 64'(o_cmd_data), 64'h5A);
    check("post_reset_ch", 64'(o_cmd_ch), 64'd3);
    drain(40);

    check("cmd_scoreboard_empty", 64'(exp_cmd.size()), 64'd0);
    check("rsp_scoreboard_empty", 64'(exp_rsp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
